req_pri_enc: RTL and testbench

- Sequential priority encoder: the encode-side counterpart of the 2-to-4 enable decoder.
- Collects one-hot/multi-hot request pulses into a sticky pending set.
- Presents the index of the highest-priority pending request on a valid/ready output port, then retires that request when it is accepted.
- Sits between event sources (interrupt/exception lines, unit done flags) and a single consumer that needs a binary index.

---
 rtl/req_pri_enc_pkg.sv | 17 +
 rtl/req_pri_enc_if.sv | 28 ++
 rtl/req_pri_enc_lsb.sv | 28 ++
 rtl/req_pri_enc.sv | 64 ++++++
 tb/tb_req_pri_enc.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/req_pri_enc_pkg.sv
// Shared constants and the lowest-set-bit helper for the request priority encoder.
package req_pri_enc_pkg;

    localparam int N_DEFAULT = 4;
    localparam int IDXW      = $clog2(N_DEFAULT);

    // Lowest index wins; an all-zero vector returns 0.
    function automatic logic [IDXW-1:0] lsb_idx(input logic [N_DEFAULT-1:0] vec);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = N_DEFAULT - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDXW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/req_pri_enc_if.sv
// Request capture and valid/ready index port of the priority encoder.
interface req_pri_enc_if
    import req_pri_enc_pkg::*;
#(
    parameter int N = N_DEFAULT
);
    localparam int IW = $clog2(N);

    logic          en;
    logic [N-1:0]  req_in;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic [N-1:0]  out_onehot;
    logic [N-1:0]  pending;
    logic          overflow;

    modport master (
        output en, req_in, out_ready,
        input  out_valid, out_idx, out_onehot, pending, overflow
    );

    modport slave (
        input  en, req_in, out_ready,
        output out_valid, out_idx, out_onehot, pending, overflow
    );

endinterface

// File: rtl/req_pri_enc_lsb.sv
// Stateless lowest-set-bit encoder: binary index plus an any-bit-set flag.
module pri_enc_lsb
    import req_pri_enc_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    assign o_any = |i_vec;

    generate
        if (N == N_DEFAULT && IW == IDXW) begin : g_pkg
            assign o_idx = lsb_idx(i_vec);
        end else begin : g_loop
            always_comb begin
                o_idx = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (i_vec[i]) o_idx = IW'(i);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/req_pri_enc.sv
// Sticky pending set feeding a registered valid/ready index output; lower index = higher priority.
module req_pri_enc
    import req_pri_enc_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    req_pri_enc_if.slave bus
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  r_pending;
    logic          r_valid;
    logic [IW-1:0] r_idx;
    logic          r_overflow;

    logic          w_fire;
    logic          w_load;
    logic [N-1:0]  w_clr;
    logic [N-1:0]  w_set;
    logic [N-1:0]  w_pend_nxt;
    logic [IW-1:0] w_nxt_idx;
    logic          w_nxt_any;
    logic [N-1:0]  w_onehot;

    assign w_onehot   = N'(1) << r_idx;
    assign w_fire     = r_valid && bus.out_ready;
    assign w_load     = !r_valid || bus.out_ready;
    assign w_clr      = w_fire ? w_onehot : '0;
    assign w_set      = bus.en ? bus.req_in : '0;
    // Set is OR'd after the clear, so a re-request on the retiring bit keeps it pending.
    assign w_pend_nxt = (r_pending & ~w_clr) | w_set;

    pri_enc_lsb #(.N(N), .IW(IW)) u_lsb (
        .i_vec (w_pend_nxt),
        .o_idx (w_nxt_idx),
        .o_any (w_nxt_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_valid    <= 1'b0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= w_pend_nxt;
            r_overflow <= |(w_set & r_pending & ~w_clr);
            // Output stage only reloads when empty or accepted: no preemption during a stall.
            if (w_load) begin
                r_valid <= w_nxt_any;
                r_idx   <= w_nxt_any ? w_nxt_idx : '0;
            end
        end
    end

    assign bus.out_valid  = r_valid;
    assign bus.out_idx    = r_idx;
    assign bus.out_onehot = r_valid ? w_onehot : '0;
    assign bus.pending    = r_pending;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_req_pri_enc.sv
// Directed-vector bench for req_pri_enc; observed state packed as {valid, idx, onehot, pending, overflow}.
module tb_req_pri_enc;
    import req_pri_enc_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    req_pri_enc_if #(.N(4)) bus ();

    req_pri_enc #(.N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        return {bus.out_valid, bus.out_idx, bus.out_onehot, bus.pending, bus.overflow};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] o;
        rst = 1'b1; bus.en = 1'b0; bus.req_in = 4'b0000; bus.out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        o = obs(); tests++;
        if (o !== 12'b0_00_0000_0000_0) begin
            $display("FAIL reset_idle got %b exp %b", o, 12'b0_00_0000_0000_0); fails++;
        end
    endtask

    task automatic test_single();
        logic [11:0] o;
        bus.en = 1'b1; bus.req_in = 4'b0100; bus.out_ready = 1'b1;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL single_no_comb got %b exp 0", bus.out_valid); fails++;
        end
        step();
        o = obs(); tests++;
        if (o !== {1'b1, 2'd2, 4'b0100, 4'b0100, 1'b0}) begin
            $display("FAIL single_present got %b exp %b", o, {1'b1, 2'd2, 4'b0100, 4'b0100, 1'b0}); fails++;
        end
        bus.req_in = 4'b0000;
        step();
        o = obs(); tests++;
        if (o !== 12'b0_00_0000_0000_0) begin
            $display("FAIL single_retired got %b exp %b", o, 12'b0_00_0000_0000_0); fails++;
        end
    endtask

    task automatic test_priority();
        logic [11:0] o;
        bus.out_ready = 1'b0; bus.req_in = 4'b1000;
        step();
        o = obs(); tests++;
        if (o !== {1'b1, 2'd3, 4'b1000, 4'b1000, 1'b0}) begin
            $display("FAIL prio_first got %b exp %b", o, {1'b1, 2'd3, 4'b1000, 4'b1000, 1'b0}); fails++;
        end
        bus.req_in = 4'b0001;
        step();
        o = obs(); tests++;
        if (o !== {1'b1, 2'd3, 4'b1000, 4'b1001, 1'b0}) begin
            $display("FAIL prio_nopreempt got %b exp %b", o, {1'b1, 2'd3, 4'b1000, 4'b1001, 1'b0}); fails++;
        end
        bus.req_in = 4'b0000;
        step();
        o = obs(); tests++;
        if (o !== {1'b1, 2'd3, 4'b1000, 4'b1001, 1'b0}) begin
            $display("FAIL prio_hold got %b exp %b", o, {1'b1, 2'd3, 4'b1000, 4'b1001, 1'b0}); fails++;
        end
        bus.out_ready = 1'b1;
        step();
        o = obs(); tests++;
        if (o !== {1'b1, 2'd0, 4'b0001, 4'b0001, 1'b0}) begin
            $display("FAIL prio_next got %b exp %b", o, {1'b1, 2'd0, 4'b0001, 4'b0001, 1'b0}); fails++;
        end
        step();
        o = obs(); tests++;
        if (o !== 12'b0_00_0000_0000_0) begin
            $display("FAIL prio_drained got %b exp %b", o, 12'b0_00_0000_0000_0); fails++;
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] o;
        logic [11:0] exp_seq [5];
        exp_seq[0] = {1'b1, 2'd0, 4'b0001, 4'b1111, 1'b0};
        exp_seq[1] = {1'b1, 2'd1, 4'b0010, 4'b1110, 1'b0};
        exp_seq[2] = {1'b1, 2'd2, 4'b0100, 4'b1100, 1'b0};
        exp_seq[3] = {1'b1, 2'd3, 4'b1000, 4'b1000, 1'b0};
        exp_seq[4] = 12'b0_00_0000_0000_0;
        bus.out_ready = 1'b1; bus.req_in = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.req_in = 4'b0000;
            o = obs(); tests++;
            if (o !== exp_seq[i]) begin
                $display("FAIL burst_%0d got %b exp %b", i, o, exp_seq[i]); fails++;
            end
        end
    endtask

    task automatic test_set_clear();
        logic [11:0] o;
        bus.out_ready = 1'b0; bus.req_in = 4'b0010;
        step();
        o = obs(); tests++;
        if (o !== {1'b1, 2'd1, 4'b0010, 4'b0010, 1'b0}) begin
            $display("FAIL sc_present got %b exp %b", o, {1'b1, 2'd1, 4'b0010, 4'b0010, 1'b0}); fails++;
        end
        bus.out_ready = 1'b1;
        step();
        o = obs(); tests++;
        if (o !== {1'b1, 2'd1, 4'b0010, 4'b0010, 1'b0}) begin
            $display("FAIL sc_set_wins got %b exp %b", o, {1'b1, 2'd1, 4'b0010, 4'b0010, 1'b0}); fails++;
        end
        bus.out_ready = 1'b0;
        step();
        o = obs(); tests++;
        if (o !== {1'b1, 2'd1, 4'b0010, 4'b0010, 1'b1}) begin
            $display("FAIL sc_overflow got %b exp %b", o, {1'b1, 2'd1, 4'b0010, 4'b0010, 1'b1}); fails++;
        end
        bus.req_in = 4'b0000;
        step();
        o = obs(); tests++;
        if (o !== {1'b1, 2'd1, 4'b0010, 4'b0010, 1'b0}) begin
            $display("FAIL sc_ovf_pulse got %b exp %b", o, {1'b1, 2'd1, 4'b0010, 4'b0010, 1'b0}); fails++;
        end
        bus.out_ready = 1'b1;
        step();
        o = obs(); tests++;
        if (o !== 12'b0_00_0000_0000_0) begin
            $display("FAIL sc_drained got %b exp %b", o, 12'b0_00_0000_0000_0); fails++;
        end
    endtask

    task automatic test_enable_reset();
        logic [11:0] o;
        bus.out_ready = 1'b0; bus.en = 1'b1; bus.req_in = 4'b0110;
        step();
        o = obs(); tests++;
        if (o !== {1'b1, 2'd1, 4'b0010, 4'b0110, 1'b0}) begin
            $display("FAIL en_load got %b exp %b", o, {1'b1, 2'd1, 4'b0010, 4'b0110, 1'b0}); fails++;
        end
        bus.en = 1'b0; bus.req_in = 4'b1111;
        step();
        o = obs(); tests++;
        if (o !== {1'b1, 2'd1, 4'b0010, 4'b0110, 1'b0}) begin
            $display("FAIL en_gated got %b exp %b", o, {1'b1, 2'd1, 4'b0010, 4'b0110, 1'b0}); fails++;
        end
        bus.en = 1'b1; rst = 1'b1;
        step();
        o = obs(); tests++;
        if (o !== 12'b0_00_0000_0000_0) begin
            $display("FAIL mid_reset got %b exp %b", o, 12'b0_00_0000_0000_0); fails++;
        end
        rst = 1'b0; bus.en = 1'b0; bus.req_in = 4'b0000;
        step();
        o = obs(); tests++;
        if (o !== 12'b0_00_0000_0000_0) begin
            $display("FAIL post_reset got %b exp %b", o, 12'b0_00_0000_0000_0); fails++;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_set_clear();
        test_enable_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
